// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Bundle of every handshake/data signal between the UART transmit arbiter,
// its NUM_REQ event senders and the shared UART transmitter.
//
//   Requester side (one bit / one byte slice per requester):
//     req, done, send, tx_data            senders -> arbiter
//     grant, block, tx_busy, data_sent    arbiter -> senders
//   UART side:
//     uart_busy, uart_data_sent           UART    -> arbiter
//     uart_tx_data, uart_send             arbiter -> UART
//   Status:
//     hold_timeout                        arbiter -> system
//
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding system's view (senders + UART)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   send;
    logic [8*NUM_REQ-1:0] tx_data;

    logic                 uart_busy;
    logic                 uart_data_sent;
    logic [7:0]           uart_tx_data;
    logic                 uart_send;

    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   block;
    logic [NUM_REQ-1:0]   tx_busy;
    logic [NUM_REQ-1:0]   data_sent;
    logic                 hold_timeout;

    modport slave (
        input  req, done, send, tx_data, uart_busy, uart_data_sent,
        output uart_tx_data, uart_send, grant, block, tx_busy, data_sent,
               hold_timeout
    );

    modport master (
        output req, done, send, tx_data, uart_busy, uart_data_sent,
        input  uart_tx_data, uart_send, grant, block, tx_busy, data_sent,
               hold_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among NUM_REQ message senders. A sender that
// wins arbitration owns the UART for a whole multi-byte message, until it
// pulses done, drops req, or exceeds MAX_HOLD cycles. Winners are chosen
// round-robin starting one past the previous owner, so nobody starves.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high reset
//   bus    - uart_tx_arbiter_if.slave; its NUM_REQ must equal this NUM_REQ
//
// Parameters:
//   NUM_REQ  - number of requesters (2..8)
//   MAX_HOLD - cycles an owner may hold the grant before forced release
//   HOLD_W   - hold counter width, 2**HOLD_W > MAX_HOLD
//
// States:
//   IDLE    - no owner; arbitrate among req
//   GRANTED - owner may forward bytes; watch for release
//   DRAIN   - released, grant kept until the last byte has left the UART
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 4096,
    parameter int HOLD_W   = 13
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    state_e               state_q,        state_d;
    logic [NUM_REQ-1:0]   grant_q,        grant_d;
    logic [PTR_W-1:0]     rr_ptr_q,       rr_ptr_d;
    logic [HOLD_W-1:0]    hold_cnt_q,     hold_cnt_d;
    logic                 uart_send_q,    uart_send_d;
    logic [7:0]           uart_tx_data_q, uart_tx_data_d;
    logic                 hold_timeout_q, hold_timeout_d;

    // -----------------------------------------------------------------------
    // Current owner decode (grant is one-hot or zero)
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] owner_idx;
    logic [7:0]       owner_byte;
    logic             owner_send;
    logic             owner_done;
    logic             owner_req;
    logic [PTR_W-1:0] next_ptr;
    logic             hit_limit;

    // NOTE: every variable written in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        owner_idx  = '0;
        owner_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx  = PTR_W'(i);
                owner_byte = bus.tx_data[8*i +: 8];
            end
        end
    end

    // Strobes from non-owners are masked out here, in every state.
    assign owner_send = |(grant_q & bus.send);
    assign owner_done = |(grant_q & bus.done);
    assign owner_req  = |(grant_q & bus.req);

    // The releasing owner gets the lowest priority next time.
    assign next_ptr  = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                          : owner_idx + PTR_W'(1);
    assign hit_limit = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

    // -----------------------------------------------------------------------
    // Round-robin winner: rotate req so rr_ptr sits at bit 0, take the lowest
    // set bit, then add rr_ptr back (mod NUM_REQ).
    // -----------------------------------------------------------------------
    logic [NUM_REQ-1:0] req_rot;
    logic               win_found;
    logic [PTR_W-1:0]   win_off;
    logic [SUM_W-1:0]   win_sum;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;

    always_comb begin
        req_rot   = NUM_REQ'({bus.req, bus.req} >> rr_ptr_q);
        win_found = 1'b0;
        win_off   = '0;
        // Descending scan: the lowest set bit is the last one written.
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                win_found = 1'b1;
                win_off   = PTR_W'(j);
            end
        end

        win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
        if (win_sum >= SUM_W'(NUM_REQ)) begin
            win_idx = PTR_W'(win_sum - SUM_W'(NUM_REQ));
        end else begin
            win_idx = PTR_W'(win_sum);
        end

        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = (win_idx == PTR_W'(i));
        end
    end

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        hold_cnt_d     = hold_cnt_q;
        uart_send_d    = 1'b0;
        uart_tx_data_d = uart_tx_data_q;
        hold_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d    = win_onehot;
                    hold_cnt_d = '0;
                    state_d    = ST_GRANTED;
                end
            end

            ST_GRANTED: begin
                // Saturate so the counter can never wrap past the limit.
                if (!hit_limit) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end

                // A byte strobed together with done is still forwarded.
                if (owner_send) begin
                    uart_send_d    = 1'b1;
                    uart_tx_data_d = owner_byte;
                end

                if (owner_done || !owner_req || hit_limit) begin
                    // grant stays up through DRAIN so data_sent reaches the owner.
                    state_d        = ST_DRAIN;
                    hold_timeout_d = hit_limit && !owner_done && owner_req;
                end
            end

            ST_DRAIN: begin
                if (!(bus.uart_busy || uart_send_q)) begin
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            rr_ptr_q       <= '0;
            hold_cnt_q     <= '0;
            uart_send_q    <= 1'b0;
            uart_tx_data_q <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_ptr_q       <= rr_ptr_d;
            hold_cnt_q     <= hold_cnt_d;
            uart_send_q    <= uart_send_d;
            uart_tx_data_q <= uart_tx_data_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.grant        = grant_q;
    assign bus.uart_send    = uart_send_q;
    assign bus.uart_tx_data = uart_tx_data_q;
    assign bus.hold_timeout = hold_timeout_q;

    assign bus.block     = {NUM_REQ{|grant_q}} & ~grant_q;
    // uart_send counts as busy so an owner cannot strobe into a byte that the
    // UART has not yet picked up.
    assign bus.tx_busy   = ~grant_q | {NUM_REQ{bus.uart_busy | uart_send_q}};
    assign bus.data_sent = grant_q & {NUM_REQ{bus.uart_data_sent}};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NUM_REQ=4, MAX_HOLD=16). Stimulus
// pushes the expected bytes, grants and timeouts into queues; a negedge
// monitor pops and compares whenever the DUT presents uart_send, a new grant
// or hold_timeout. A small UART model answers each uart_send with a busy
// window and a data_sent pulse.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int UART_CYC = 3;

    typedef struct {
        logic [7:0] data;
        logic [3:0] owner;
    } byte_exp_t;

    logic clk;
    logic reset;
    logic force_busy;
    logic model_busy;
    logic model_ds;
    int   model_cnt;

    int n_checks = 0;
    int n_errors = 0;

    byte_exp_t  exp_byte_q[$];
    logic [3:0] exp_grant_q[$];
    logic [3:0] exp_to_q[$];
    logic [3:0] prev_grant = '0;
    logic [7:0] last_byte  = '0;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_HOLD (16),
        .HOLD_W   (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: busy for UART_CYC cycles after each strobe, then data_sent.
    assign bus.uart_busy      = model_busy | force_busy;
    assign bus.uart_data_sent = model_ds;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_busy <= 1'b0;
            model_ds   <= 1'b0;
            model_cnt  <= 0;
        end else begin
            model_ds <= 1'b0;
            if (bus.uart_send) begin
                model_busy <= 1'b1;
                model_cnt  <= UART_CYC;
            end else if (model_busy) begin
                if (model_cnt == 1) begin
                    model_busy <= 1'b0;
                    model_ds   <= 1'b1;
                end
                model_cnt <= model_cnt - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        oh = 4'b0001 << i;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        byte_exp_t  e;
        logic [3:0] g;
        if (!reset) begin
            if (bus.uart_send) begin
                if (exp_byte_q.size() == 0) begin
                    check("uart_send_unexpected", bus.uart_send, 0);
                end else begin
                    e = exp_byte_q.pop_front();
                    check("uart_tx_data", bus.uart_tx_data, e.data);
                    check("send_owner", bus.grant, e.owner);
                end
            end
            if (bus.grant != prev_grant) begin
                if (prev_grant != 4'b0000) begin
                    check("idle_gap", bus.grant, 0);
                end else if (exp_grant_q.size() == 0) begin
                    check("grant_unexpected", bus.grant, 0);
                end else begin
                    g = exp_grant_q.pop_front();
                    check("grant_seq", bus.grant, g);
                end
            end
            if (bus.hold_timeout) begin
                if (exp_to_q.size() == 0) begin
                    check("timeout_unexpected", bus.hold_timeout, 0);
                end else begin
                    g = exp_to_q.pop_front();
                    check("timeout_owner", bus.grant, g);
                end
            end
        end
        prev_grant = bus.grant;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until grant equals exp; check grant and block there.
    task automatic wait_grant(input logic [3:0] exp, input string name);
        int         n;
        logic [3:0] exp_blk;
        n = 0;
        exp_blk = (exp != 4'b0000) ? ~exp : 4'b0000;
        @(negedge clk);
        while (bus.grant !== exp && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.grant, exp);
        check({name, "_block"}, bus.block, exp_blk);
        cyc();
    endtask

    task automatic wait_data_sent(input int idx);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.data_sent[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("data_sent", bus.data_sent, oh(idx));
        cyc();
    endtask

    task automatic send_byte(input int idx, input logic [7:0] data,
                             input bit wait_ds);
        byte_exp_t e;
        e.data  = data;
        e.owner = oh(idx);
        exp_byte_q.push_back(e);
        last_byte = data;
        bus.tx_data[idx*8 +: 8] = data;
        bus.send[idx] = 1'b1;
        cyc();
        bus.send[idx] = 1'b0;
        if (wait_ds) wait_data_sent(idx);
    endtask

    task automatic pulse_done(input int idx, input bit drop_all_req);
        bus.done[idx] = 1'b1;
        if (drop_all_req) bus.req = '0;
        cyc();
        bus.done[idx] = 1'b0;
    endtask

    logic [7:0] cont_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int n;
        reset      = 1'b1;
        force_busy = 1'b0;
        bus.req    = '0;
        bus.done   = '0;
        bus.send   = '0;
        bus.tx_data = '0;

        // ---------------- reset values ----------------
        cyc();
        check("rst_tx_busy", bus.tx_busy, 4'b1111);
        check("rst_grant", bus.grant, 0);
        check("rst_block", bus.block, 0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_grant", bus.grant, 0);
        check("post_rst_block", bus.block, 0);
        check("post_rst_tx_busy", bus.tx_busy, 4'b1111);
        check("post_rst_uart_send", bus.uart_send, 0);
        check("post_rst_uart_tx_data", bus.uart_tx_data, 0);
        check("post_rst_hold_timeout", bus.hold_timeout, 0);
        check("post_rst_data_sent", bus.data_sent, 0);
        cyc();

        // ---------------- single requester ----------------
        bus.req[2] = 1'b1;
        exp_grant_q.push_back(4'b0100);
        @(negedge clk);
        check("single_grant_latency", bus.grant, 0);
        cyc();
        @(negedge clk);
        check("single_grant", bus.grant, 4'b0100);
        check("single_block", bus.block, 4'b1011);
        check("single_tx_busy", bus.tx_busy, 4'b1011);
        cyc();
        send_byte(2, 8'hAE, 1'b1);
        send_byte(2, 8'h10, 1'b0);
        pulse_done(2, 1'b1);
        wait_data_sent(2);
        @(negedge clk);
        check("single_release", bus.grant, 0);
        cyc();

        // rr_ptr must now be 3: requester 3 beats requester 0.
        bus.req = 4'b1001;
        exp_grant_q.push_back(4'b1000);
        wait_grant(4'b1000, "rr_after_single");
        pulse_done(3, 1'b1);
        wait_grant(4'b0000, "rr_probe_idle");

        // ---------------- contention ----------------
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) exp_grant_q.push_back(oh(k));
        exp_grant_q.push_back(4'b0001);
        for (int k = 0; k < 4; k++) begin
            wait_grant(oh(k), "cont_grant");
            send_byte(k, cont_bytes[k], 1'b1);
            pulse_done(k, 1'b0);
        end
        wait_grant(4'b0001, "cont_wrap");

        // ---------------- isolation (owner 0) ----------------
        bus.tx_data[15:8] = 8'h55;
        bus.send[1] = 1'b1;
        bus.done[1] = 1'b1;
        cyc();
        bus.send[1] = 1'b0;
        bus.done[1] = 1'b0;
        @(negedge clk);
        check("iso_uart_send", bus.uart_send, 0);
        check("iso_uart_tx_data", bus.uart_tx_data, last_byte);
        check("iso_tx_busy", bus.tx_busy, 4'b1110);
        check("iso_grant_kept", bus.grant, 4'b0001);
        cyc();
        send_byte(0, 8'h3C, 1'b1);
        pulse_done(0, 1'b1);
        wait_grant(4'b0000, "iso_idle");

        // ---------------- hold timeout ----------------
        bus.req[3] = 1'b1;
        exp_grant_q.push_back(4'b1000);
        exp_to_q.push_back(4'b1000);
        wait_grant(4'b1000, "to_grant");
        n = 1;
        @(negedge clk);
        while (!bus.hold_timeout && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", n, 16);
        check("to_grant_in_drain", bus.grant, 4'b1000);
        bus.req = 4'b0001;
        exp_grant_q.push_back(4'b0001);
        @(negedge clk);
        check("to_one_cycle", bus.hold_timeout, 0);
        check("to_released", bus.grant, 0);
        cyc();
        wait_grant(4'b0001, "to_next_grant");
        pulse_done(0, 1'b1);
        wait_grant(4'b0000, "to_idle");

        // ---------------- drain timing ----------------
        bus.req[1] = 1'b1;
        exp_grant_q.push_back(4'b0010);
        wait_grant(4'b0010, "drain_grant");
        force_busy = 1'b1;
        bus.req = 4'b0100;
        exp_grant_q.push_back(4'b0100);
        pulse_done(1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("drain_hold", bus.grant, 4'b0010);
            cyc();
        end
        force_busy = 1'b0;
        @(negedge clk);
        check("drain_last", bus.grant, 4'b0010);
        @(negedge clk);
        check("drain_gap", bus.grant, 0);
        @(negedge clk);
        check("drain_next", bus.grant, 4'b0100);
        cyc();

        // ---------------- reset mid-message ----------------
        bus.tx_data[23:16] = 8'hC3;
        bus.send[2] = 1'b1;
        cyc();
        bus.send[2] = 1'b0;
        check("pre_rst_uart_send", bus.uart_send, 1);
        reset = 1'b1;
        bus.req = '0;
        #1;
        check("mid_rst_uart_send", bus.uart_send, 0);
        check("mid_rst_grant", bus.grant, 0);
        check("mid_rst_tx_busy", bus.tx_busy, 4'b1111);
        check("mid_rst_uart_tx_data", bus.uart_tx_data, 0);
        cyc();
        cyc();
        reset = 1'b0;
        bus.req = 4'b1010;
        exp_grant_q.push_back(4'b0010);
        wait_grant(4'b0010, "rst_rr_restart");
        pulse_done(1, 1'b1);
        wait_grant(4'b0000, "final_idle");

        check("byte_q_empty", exp_byte_q.size(), 0);
        check("grant_q_empty", exp_grant_q.size(), 0);
        check("timeout_q_empty", exp_to_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among NUM_REQ event senders (end-game, move-ack, board-dump, etc.).
- A sender owns the UART for a whole multi-byte message, from grant until it signals done.
- Grants are round-robin, so no sender starves.
- Non-owners see block=1 and tx_busy=1, so they hold off in their own idle states.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_HOLD, 4096, maximum cycles a requester may hold the grant before a forced release.
- HOLD_W, 13, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester level request; held high while the requester wants the UART.
- done  in  NUM_REQ  per-requester one-cycle pulse: message finished, release the grant.
- send  in  NUM_REQ  per-requester byte strobe (one cycle).
- tx_data  in  8*NUM_REQ  per-requester byte; slice i is bits [8i+7:8i].
- uart_busy  in  1  UART transmitter busy.
- uart_data_sent  in  1  UART one-cycle pulse: byte finished.
- uart_tx_data  out  8  byte to UART (registered).
- uart_send  out  1  send strobe to UART (registered).
- grant  out  NUM_REQ  one-hot current owner; all zero when no owner.
- block  out  NUM_REQ  per-requester inhibit; 1 = another requester owns the UART.
- tx_busy  out  NUM_REQ  per-requester busy view.
- data_sent  out  NUM_REQ  per-requester byte-done pulse.
- hold_timeout  out  1  one-cycle pulse on a forced release.

Behaviour:

Reset:
- Asynchronous, active-high.
- Registers clear: state=IDLE, grant=0, rr_ptr=0, hold_cnt=0, uart_send=0, uart_tx_data=0, hold_timeout=0.
- Reset mid-message aborts the message with no strobe issued.

Combinational outputs:
- block[i] = |grant & ~grant[i]. Reads all zero in IDLE and at reset.
- tx_busy[i] = ~grant[i] | uart_busy | uart_send. Reads all ones at reset.
- data_sent[i] = grant[i] & uart_data_sent.

Byte path:
- In GRANTED, when the owner pulses send, the next edge loads uart_tx_data from the owner's slice and sets uart_send=1 for exactly one cycle. Latency is 1 cycle.
- send from non-owners is ignored in every state.
- In all other cycles uart_send=0 and uart_tx_data holds its value.

State machine (IDLE, GRANTED, DRAIN):

IDLE:
- If req≠0, pick the first set req index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- Next edge: grant=onehot(winner), hold_cnt=0, state=GRANTED.
- The grant takes effect one cycle after req is seen.

GRANTED:
- hold_cnt increments each cycle.
- Release on done[owner], on req[owner]=0, or on hold_cnt==MAX_HOLD-1.
- On release: state=DRAIN. grant stays asserted so data_sent reaches the owner.
- On timeout release only, hold_timeout pulses for 1 cycle.
- If done and send occur in the same cycle, the byte is still forwarded, then release follows.

DRAIN:
- Wait while uart_busy | uart_send.
- Then grant=0, rr_ptr=(owner+1) mod NUM_REQ, state=IDLE.
- A new grant may be issued on the following edge, so ownership changes have a minimum of 1 idle cycle between them.

Round-robin rule:
- A requester that just released has the lowest priority on the next arbitration.

Boundary conditions:
- A req that drops during IDLE is never granted.
- done or req changes from non-owners are ignored.
- rr_ptr wraps from NUM_REQ-1 to 0.
- hold_cnt saturates at MAX_HOLD-1; it cannot wrap before release.
- An illegal state code returns to IDLE with grant=0.

Test Plan:
- Single requester: req[2]=1; two send pulses with bytes 0xAE then 0x10; then done[2] → grant=0100 one cycle after req; uart_send pulses carry 0xAE and 0x10 in order; after uart_busy falls, grant=0000 and rr_ptr=3.
- Contention: req=1111 held, each owner sends 1 byte then pulses done, starting with rr_ptr=0 → grant sequence 0001, 0010, 0100, 1000, 0001; block equals ~grant in each GRANTED window.
- Isolation: owner 0 granted; requester 1 pulses send with 0x55 → uart_send stays 0, uart_tx_data is unchanged, tx_busy[1]=1, data_sent[1] stays 0 when uart_data_sent pulses.
- Timeout: MAX_HOLD=16; requester 3 granted, never sends done → hold_timeout pulses 16 cycles after the grant; grant releases after drain; the next req[0] is granted.
- Drain and edge timing: done[1] while uart_busy=1 → grant stays 0010 until uart_busy=0; then 0000; no new grant in that same cycle.
- Reset mid-message: assert reset while uart_send=1 and grant=0100 → immediately uart_send=0, grant=0000, tx_busy=all 1; after release, arbitration restarts from rr_ptr=0.
